// File: rtl/board_mem_wb_slave.sv
// Wishbone classic slave holding the Minesweeper board-state RAM, with a
// self-timed bulk clear that fills every cell with CLEAR_VALUE.
module board_mem_wb_slave #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 16,
  parameter int                DEPTH       = 256,
  parameter int                WAIT_STATES = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_stall_o,
  input  logic              clear_req_i,
  output logic              clear_busy_o,
  output logic              clear_done_o,
  output logic              addr_err_o
);

  localparam int              IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW        = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W:0] DEPTH_A   = (ADDR_W+1)'(DEPTH);
  localparam logic [CW-1:0]   LAST_CELL = CW'(DEPTH - 1);
  localparam logic [3:0]      WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [CW-1:0]     clr_cnt_q, clr_cnt_d;
  logic              clr_pend_q, clr_pend_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] dat_q, dat_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] op_adr;
  logic              op_we;
  logic [DATA_W-1:0] op_dat;
  logic              op_valid;
  logic              enter_ack;
  logic [IW-1:0]     op_idx;
  logic [IW-1:0]     clr_idx;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    clr_cnt_d  = clr_cnt_q;
    clr_pend_d = clr_pend_q;
    adr_d      = adr_q;
    we_d       = we_q;
    dat_d      = dat_q;
    case (state_q)
      S_IDLE: begin
        if (clear_req_i || clr_pend_q) begin
          state_d    = S_CLEAR;
          clr_cnt_d  = '0;
          clr_pend_d = 1'b0;
        end else if (wb_cyc_i && wb_stb_i) begin
          adr_d      = wb_adr_i;
          we_d       = wb_we_i;
          dat_d      = wb_dat_i;
          wait_cnt_d = WAIT_INIT;
          state_d    = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i)              state_d = S_IDLE;
        else if (wait_cnt_q == 4'd0) state_d = S_ACK;
        else                        wait_cnt_d = wait_cnt_q - 4'd1;
      end
      S_ACK:   state_d = S_IDLE;
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + CW'(1);
        if (clr_cnt_q == LAST_CELL) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Requests seen while busy are remembered and merged into one clear.
    if (state_q != S_IDLE && clear_req_i) clr_pend_d = 1'b1;
  end

  // With zero wait states the transfer completes on the acceptance edge,
  // so the operands come straight from the bus rather than the latches.
  assign op_adr    = (state_q == S_IDLE) ? wb_adr_i : adr_q;
  assign op_we     = (state_q == S_IDLE) ? wb_we_i  : we_q;
  assign op_dat    = (state_q == S_IDLE) ? wb_dat_i : dat_q;
  assign op_valid  = {1'b0, op_adr} < DEPTH_A;
  assign enter_ack = (state_d == S_ACK) && (state_q != S_ACK);
  assign op_idx    = op_adr[IW-1:0];
  assign clr_idx   = clr_cnt_q[IW-1:0];

  assign wb_stall_o = (state_q == S_WAIT) || (state_q == S_CLEAR);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == S_CLEAR)                    mem[clr_idx] <= CLEAR_VALUE;
      else if (enter_ack && op_we && op_valid)   mem[op_idx]  <= op_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= '0;
      clr_cnt_q    <= '0;
      clr_pend_q   <= 1'b0;
      adr_q        <= '0;
      we_q         <= 1'b0;
      dat_q        <= '0;
      wb_ack_o     <= 1'b0;
      wb_dat_o     <= '0;
      clear_busy_o <= 1'b0;
      clear_done_o <= 1'b0;
      addr_err_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      clr_cnt_q    <= clr_cnt_d;
      clr_pend_q   <= clr_pend_d;
      adr_q        <= adr_d;
      we_q         <= we_d;
      dat_q        <= dat_d;
      wb_ack_o     <= (state_d == S_ACK);
      clear_busy_o <= (state_d == S_CLEAR);
      clear_done_o <= (state_q == S_CLEAR) && (clr_cnt_q == LAST_CELL);
      if (enter_ack && !op_we) wb_dat_o <= op_valid ? mem[op_idx] : '0;
      if (enter_ack && !op_valid) addr_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_board_mem_wb_slave.sv
// Bench for board_mem_wb_slave: four instances with different WAIT_STATES/DEPTH,
// read data checked against a reference memory through an expected-value queue.
module tb_board_mem_wb_slave;

  logic        clk = 1'b0;
  logic        rst_n [4];
  logic        cyc [4], stb [4], we [4], creq [4];
  logic [7:0]  adr [4];
  logic [15:0] dati [4], dato [4];
  logic        ack [4], stall [4], cbusy [4], cdone [4], aerr [4];

  int          depth_of [4] = '{256, 256, 256, 200};
  logic [15:0] model [4][256];
  logic [15:0] sb_q [$];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  // 0: WS=1, 1: WS=0, 2: WS=3, 3: WS=1 with DEPTH=200
  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    board_mem_wb_slave #(
      .ADDR_W(8), .DATA_W(16),
      .DEPTH((gi == 3) ? 200 : 256),
      .WAIT_STATES((gi == 1) ? 0 : (gi == 2) ? 3 : 1),
      .CLEAR_VALUE(16'h0000)
    ) u_dut (
      .clk(clk), .rst_n(rst_n[gi]),
      .wb_cyc_i(cyc[gi]), .wb_stb_i(stb[gi]), .wb_we_i(we[gi]),
      .wb_adr_i(adr[gi]), .wb_dat_i(dati[gi]), .wb_dat_o(dato[gi]),
      .wb_ack_o(ack[gi]), .wb_stall_o(stall[gi]),
      .clear_req_i(creq[gi]), .clear_busy_o(cbusy[gi]),
      .clear_done_o(cdone[gi]), .addr_err_o(aerr[gi])
    );
  end

  // Bus driver: pushes the expected read word, waits (bounded) for ack.
  task automatic xfer(input int k, input bit w, input logic [7:0] a, input logic [15:0] d,
                      output int lat, output int st, output logic [15:0] rd, output bit to);
    lat = 0; st = 0; rd = '0; to = 1'b1;
    if (!w) sb_q.push_back((int'(a) < depth_of[k]) ? model[k][a] : 16'h0000);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; dati[k] = d;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ack[k]) begin
        to = 1'b0; rd = dato[k];
        break;
      end
      if (stall[k]) st++;
    end
    if (w && !to && int'(a) < depth_of[k]) model[k][a] = d;
    cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic model_clear(input int k, input int upto);
    for (int i = 0; i < upto; i++) model[k][i] = 16'h0000;
  endtask

  task automatic test_reset;
    for (int k = 0; k < 4; k++) begin
      rst_n[k] = 1'b0; cyc[k] = 0; stb[k] = 0; we[k] = 0; creq[k] = 0; adr[k] = 0; dati[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({ack[k], stall[k], cbusy[k], cdone[k], aerr[k], dato[k]} !== 21'h0) begin
        failures++;
        $display("FAIL reset inst%0d: ack=%b stall=%b busy=%b done=%b err=%b dat=%h, all required 0",
                 k, ack[k], stall[k], cbusy[k], cdone[k], aerr[k], dato[k]);
      end
      rst_n[k] = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ws1_rw;
    int lat, st; logic [15:0] rd, exp; bit to;
    for (int p = 0; p < 2; p++) begin
      xfer(0, p == 0, 8'h05, 16'hA5A5, lat, st, rd, to);
      checks++;
      if (to || lat != 2 || st != 1) begin
        failures++;
        $display("FAIL ws1_timing op%0d: timeout=%0d lat=%0d stall=%0d, required lat=2 stall=1", p, to, lat, st);
      end
      if (p == 1) begin
        exp = sb_q.pop_front();
        checks++;
        if (rd !== exp) begin
          failures++;
          $display("FAIL ws1_read: got %h expected %h", rd, exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, st; logic [15:0] rd, exp; bit to;
    for (int p = 0; p < 8; p++) begin
      xfer(1, p < 4, 8'(p % 4), 16'(p % 4 + 1), lat, st, rd, to);
      checks++;
      if (to || lat != 1 || st != 0) begin
        failures++;
        $display("FAIL b2b_timing op%0d: timeout=%0d lat=%0d stall=%0d, required lat=1 stall=0", p, to, lat, st);
      end
      if (p >= 4) begin
        exp = sb_q.pop_front();
        checks++;
        if (rd !== exp) begin
          failures++;
          $display("FAIL b2b_read adr%0d: got %h expected %h", p % 4, rd, exp);
        end
      end
    end
  endtask

  task automatic test_clear;
    int lat, st, nbusy, ndone; logic [15:0] rd, exp; bit to;
    xfer(0, 1'b1, 8'd10, 16'h1234, lat, st, rd, to);
    creq[0] = 1'b1;
    nbusy = 0; ndone = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      creq[0] = 1'b0;
      if (cbusy[0]) nbusy++;
      if (cdone[0]) ndone++;
    end
    model_clear(0, 256);
    checks++;
    if (nbusy != 256 || ndone != 1) begin
      failures++;
      $display("FAIL clear_timing: busy_cycles=%0d done_pulses=%0d, required 256 and 1", nbusy, ndone);
    end
    xfer(0, 1'b0, 8'd10, 16'h0, lat, st, rd, to);
    exp = sb_q.pop_front();
    checks++;
    if (to || rd !== exp) begin
      failures++;
      $display("FAIL clear_read: timeout=%0d got %h expected %h", to, rd, exp);
    end
  endtask

  task automatic test_clear_priority;
    int lat, st, n, bad_stall, early; logic [15:0] rd, exp; bit to, done_seen, acked;
    xfer(1, 1'b1, 8'd7, 16'hBEEF, lat, st, rd, to);
    model_clear(1, 256);
    sb_q.push_back(model[1][7]);
    creq[1] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 8'd7;
    n = 0; bad_stall = 0; early = 0; done_seen = 0; acked = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      creq[1] = 1'b0;
      n++;
      if (n <= 256 && !stall[1]) bad_stall++;
      if (!done_seen && ack[1]) early++;
      if (cdone[1]) done_seen = 1'b1;
      if (ack[1]) begin
        acked = 1'b1; rd = dato[1];
        break;
      end
    end
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (!acked || n != 258 || bad_stall != 0 || early != 0 || !done_seen) begin
      failures++;
      $display("FAIL clear_priority: acked=%0d ack_edge=%0d stall_gaps=%0d early_acks=%0d done=%0d, required 1/258/0/0/1",
               acked, n, bad_stall, early, done_seen);
    end
    exp = sb_q.pop_front();
    checks++;
    if (rd !== exp) begin
      failures++;
      $display("FAIL clear_priority_read: got %h expected %h", rd, exp);
    end
  endtask

  task automatic test_addr_err;
    int lat, st; logic [15:0] rd, exp; bit to;
    xfer(3, 1'b1, 8'hF0, 16'hFFFF, lat, st, rd, to);
    checks++;
    if (to || aerr[3] !== 1'b1) begin
      failures++;
      $display("FAIL addr_err_write: timeout=%0d err=%b, required ack and err=1", to, aerr[3]);
    end
    xfer(3, 1'b0, 8'hF0, 16'h0, lat, st, rd, to);
    exp = sb_q.pop_front();
    checks++;
    if (to || rd !== exp) begin
      failures++;
      $display("FAIL addr_err_read: timeout=%0d got %h expected %h", to, rd, exp);
    end
    xfer(3, 1'b1, 8'd3, 16'h0BAD, lat, st, rd, to);
    xfer(3, 1'b0, 8'd3, 16'h0, lat, st, rd, to);
    exp = sb_q.pop_front();
    checks++;
    if (rd !== exp || aerr[3] !== 1'b1) begin
      failures++;
      $display("FAIL addr_err_sticky: read %h expected %h, err=%b required 1", rd, exp, aerr[3]);
    end
    rst_n[3] = 1'b0;
    @(posedge clk); #1;
    rst_n[3] = 1'b1;
    checks++;
    if (aerr[3] !== 1'b0) begin
      failures++;
      $display("FAIL addr_err_reset: err=%b required 0", aerr[3]);
    end
  endtask

  task automatic test_abort;
    int lat, st, nack; logic [15:0] rd, exp; bit to, st_mid;
    xfer(2, 1'b1, 8'd2, 16'h1111, lat, st, rd, to);
    checks++;
    if (to || lat != 4 || st != 3) begin
      failures++;
      $display("FAIL ws3_timing: timeout=%0d lat=%0d stall=%0d, required lat=4 stall=3", to, lat, st);
    end
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 8'd2; dati[2] = 16'h7777;
    repeat (2) @(posedge clk);
    #1;
    st_mid = stall[2];
    cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
    nack = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack[2]) nack++;
    end
    checks++;
    if (st_mid !== 1'b1 || nack != 0) begin
      failures++;
      $display("FAIL abort: stall_in_wait=%b acks=%0d, required 1 and 0", st_mid, nack);
    end
    xfer(2, 1'b0, 8'd2, 16'h0, lat, st, rd, to);
    exp = sb_q.pop_front();
    checks++;
    if (to || rd !== exp) begin
      failures++;
      $display("FAIL abort_read: timeout=%0d got %h expected %h", to, rd, exp);
    end
  endtask

  task automatic test_reset_mid_clear;
    int lat, st; logic [15:0] rd, exp; bit to, busy_mid;
    xfer(0, 1'b1, 8'd5, 16'h5555, lat, st, rd, to);
    xfer(0, 1'b1, 8'd200, 16'hC0DE, lat, st, rd, to);
    xfer(0, 1'b0, 8'd5, 16'h0, lat, st, rd, to);
    void'(sb_q.pop_front());
    creq[0] = 1'b1;
    @(posedge clk); #1;
    creq[0] = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    busy_mid = cbusy[0];
    rst_n[0] = 1'b0;
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    checks++;
    if (busy_mid !== 1'b1 ||
        {ack[0], stall[0], cbusy[0], cdone[0], aerr[0], dato[0]} !== 21'h0) begin
      failures++;
      $display("FAIL reset_mid_clear: busy_before=%b ack=%b stall=%b busy=%b done=%b err=%b dat=%h, required busy_before=1 rest 0",
               busy_mid, ack[0], stall[0], cbusy[0], cdone[0], aerr[0], dato[0]);
    end
    model_clear(0, 32);
    for (int p = 0; p < 2; p++) begin
      xfer(0, 1'b0, (p == 0) ? 8'd5 : 8'd200, 16'h0, lat, st, rd, to);
      exp = sb_q.pop_front();
      checks++;
      if (to || lat != 2 || rd !== exp) begin
        failures++;
        $display("FAIL post_abort_read%0d: timeout=%0d lat=%0d got %h, required lat=2 data %h", p, to, lat, rd, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ws1_rw();
    test_back_to_back();
    test_clear();
    test_clear_priority();
    test_addr_err();
    test_abort();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/board_mem_wb_slave.md
Name: board_mem_wb_slave

Overview:
Wishbone classic slave that holds the Minesweeper board-state memory (one DATA_W word per cell). It sits directly downstream of the team's Wishbone master, on the same wishbone bus, and answers its single reads and writes with stall/ack. It also provides a self-timed bulk-clear sequence that a new-game event triggers, which fills every cell with CLEAR_VALUE.

Parameters:
ADDR_W, 8, address width of wb_adr_i.
DATA_W, 16, data width of the bus and of each memory word.
DEPTH, 256, number of implemented words (DEPTH <= 2**ADDR_W).
WAIT_STATES, 1, extra cycles inserted between request acceptance and ack (0..15).
CLEAR_VALUE, 16'h0000, word written to every cell during a bulk clear.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst_n  in  1  synchronous reset, active-low.
wb_cyc_i  in  1  bus cycle valid.
wb_stb_i  in  1  strobe; the master holds it until it samples ack=1 with stall=0.
wb_we_i  in  1  1 = write, 0 = read.
wb_adr_i  in  ADDR_W  word address.
wb_dat_i  in  DATA_W  write data.
wb_dat_o  out  DATA_W  read data; valid in the ack cycle.
wb_ack_o  out  1  one-cycle transfer acknowledge.
wb_stall_o  out  1  slave busy; the master must keep the request pending.
clear_req_i  in  1  one-cycle pulse that requests a bulk clear.
clear_busy_o  out  1  high while the clear sequence runs.
clear_done_o  out  1  one-cycle pulse after the last cell is written.
addr_err_o  out  1  sticky flag; set on any access with wb_adr_i >= DEPTH; cleared only by reset.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state goes to IDLE; wait counter, clear counter and clear-pending flag go to 0.
  - wb_ack_o, wb_dat_o, clear_busy_o, clear_done_o and addr_err_o go to 0.
  - Memory contents are not reset; they infer as RAM.
  - A reset during WAIT or CLEAR aborts the operation. Cells already cleared stay cleared.
- wb_stall_o is combinational: it is 1 in WAIT and in CLEAR, and 0 in IDLE and in ACK.
- States:
  - IDLE
    - clear_req_i=1 or clear-pending=1: go to CLEAR, clear counter=0. This takes priority over a simultaneous bus request; that request stays pending because stall=1.
    - Otherwise, wb_cyc_i&wb_stb_i=1: latch adr, we and dat.
      - WAIT_STATES=0: go to ACK.
      - WAIT_STATES>0: go to WAIT with wait counter=WAIT_STATES-1.
    - stb=1 with cyc=0 is ignored.
  - WAIT
    - Counter decrements each cycle; at 0, go to ACK.
    - wb_cyc_i=0 in any WAIT cycle: abort to IDLE. No memory write, no ack.
  - ACK-entry edge (the transition into ACK)
    - Write with addr < DEPTH: mem[addr] <= dat.
    - Read: wb_dat_o <= mem[addr], or 0 if addr >= DEPTH.
    - addr >= DEPTH: write ignored, addr_err_o <= 1.
  - ACK
    - wb_ack_o=1 for exactly one cycle, with stall=0; then go to IDLE.
    - wb_dat_o holds its value until the next read.
  - CLEAR
    - Each cycle writes mem[cnt] <= CLEAR_VALUE and increments cnt. clear_busy_o=1.
    - After cell DEPTH-1: clear_done_o=1 for one cycle, clear_busy_o=0, go to IDLE.
    - Takes exactly DEPTH cycles.
- clear_req_i arriving in WAIT, ACK or CLEAR sets clear-pending. It is serviced on the next IDLE cycle, after the current bus transfer completes. Multiple requests merge into one clear.
- Latency from accepted request to ack, with the master sampling on the next edge:
  - WAIT_STATES=0: ack is visible 1 cycle after acceptance.
  - WAIT_STATES=N: ack is visible N+1 cycles after acceptance.
- Back-to-back operation: the master drops stb on the edge after ack, so IDLE can accept a new request 1 cycle after ACK.
- Address and data arithmetic is unsigned, at full ADDR_W/DATA_W width. The clear counter is $clog2(DEPTH)+1 bits wide, so it cannot wrap.

Test Plan:
1. WAIT_STATES=1: write adr 8'h05 data 16'hA5A5, then read adr 8'h05 → ack 2 cycles after each acceptance, stall=1 for 1 cycle each time, read returns 16'hA5A5.
2. WAIT_STATES=0: four back-to-back writes to 0..3 (values 1..4), then reads → each ack 1 cycle after acceptance, reads return 1,2,3,4, stall never asserted.
3. Write 16'h1234 to adr 10, then pulse clear_req_i → clear_busy_o high for exactly 256 cycles, a single clear_done_o pulse, then a read of adr 10 returns 16'h0000.
4. Raise stb in the same cycle as clear_req_i → clear runs first with stall=1 throughout; the pending read is acked only after clear_done_o, with data CLEAR_VALUE.
5. DEPTH=200: write 16'hFFFF to adr 8'hF0, then read adr 8'hF0 → both acked, read returns 0, addr_err_o=1 and stays set until rst_n=0.
6. Drop cyc during WAIT (WAIT_STATES=3) on a write of 16'h7777 to adr 2 → no ack, mem[2] unchanged; a separate run asserts rst_n=0 mid-clear → all outputs 0 and state IDLE on the following cycle.
